mult_div_seq: RTL and testbench

Iterative multiply/divide sequencer with HI/LO registers, sitting beside the main ALU in the EX stage. It decodes R-type mult/multu/div/divu/mfhi/mflo/mthi/mtlo, runs a 32-iteration shift-add or restoring-divide loop, and writes HI/LO. While the loop runs, it raises a pipeline stall for any dependent HI/LO instruction.

---
 rtl/mult_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_mult_div_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq.sv
// Iterative multiply/divide sequencer with HI/LO registers for the EX stage.
// Decodes R-type mult/multu/div/divu/mfhi/mflo/mthi/mtlo, runs an XLEN-cycle
// shift-add or restoring-divide loop and stalls dependent HI/LO instructions.
module mult_div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [1:0]      ALUOp,
  input  logic [5:0]      FuncCode,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hilo_out,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     counter;
  logic [2*XLEN-1:0] acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
  logic [XLEN-1:0]   rs_raw;    // unmodified rs, returned in HI on divide by zero
  logic              op_div;
  logic              neg_main;  // negate product / quotient
  logic              neg_rem;   // negate remainder
  logic              rt_zero;

  // Instruction decode
  logic            dec_en;
  logic            is_md;
  logic            is_signed;
  logic            is_div;
  logic            is_mfhi;
  logic            is_mflo;
  logic            is_mthi;
  logic            is_mtlo;
  logic            is_hilo;
  logic            accept;
  logic [XLEN-1:0] abs_rs;
  logic [XLEN-1:0] abs_rt;

  // Decode of funct field, gated by a valid R-type instruction in EX
  always_comb begin
    dec_en    = ex_valid && (ALUOp == 2'b10);
    is_md     = 1'b0;
    is_signed = 1'b0;
    is_div    = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    if (dec_en) begin
      case (FuncCode)
        F_MULT:  begin is_md = 1'b1; is_signed = 1'b1; end
        F_MULTU: begin is_md = 1'b1; end
        F_DIV:   begin is_md = 1'b1; is_signed = 1'b1; is_div = 1'b1; end
        F_DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
        F_MFHI:  is_mfhi = 1'b1;
        F_MFLO:  is_mflo = 1'b1;
        F_MTHI:  is_mthi = 1'b1;
        F_MTLO:  is_mtlo = 1'b1;
        default: ;
      endcase
    end
    is_hilo = is_md | is_mfhi | is_mflo | is_mthi | is_mtlo;
    stall   = is_hilo & busy;
    accept  = is_md & ~stall & (state == IDLE);
    abs_rs  = (is_signed && rs_data[XLEN-1]) ? -rs_data : rs_data;
    abs_rt  = (is_signed && rt_data[XLEN-1]) ? -rt_data : rt_data;
  end

  // HI/LO read path, valid in the same cycle as mfhi/mflo
  always_comb begin
    hilo_out = '0;
    if (is_mfhi)      hilo_out = hi;
    else if (is_mflo) hilo_out = lo;
  end

  // One loop iteration and the final sign-corrected result
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_up;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    // Remainder shifted left with the next dividend bit; a set bit 32 of the
    // difference marks a borrow, i.e. the trial subtraction must be undone.
    div_up   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_up - {1'b0, opb};
    if (op_div) begin
      if (!div_diff[XLEN]) acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 acc_next = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_next = {mul_sum, acc[XLEN-1:1]};
      else        acc_next = {1'b0, acc[2*XLEN-1:1]};
    end

    prod = neg_main ? -acc : acc;
    quo  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op_div) begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end else if (rt_zero) begin
      res_hi = rs_raw;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // Sequencer FSM with registered HI/LO, busy, done and div_by_zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      acc         <= '0;
      opb         <= '0;
      rs_raw      <= '0;
      op_div      <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      rt_zero     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= {{XLEN{1'b0}}, abs_rs};
            opb      <= abs_rt;
            rs_raw   <= rs_data;
            op_div   <= is_div;
            neg_main <= is_signed & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            neg_rem  <= is_signed & rs_data[XLEN-1];
            rt_zero  <= (rt_data == '0);
            counter  <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            if (is_mthi) hi <= rs_data;
            if (is_mtlo) lo <= rs_data;
          end
        end
        RUN: begin
          acc     <= acc_next;
          counter <= counter + 1'b1;
          if (counter == CW'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          hi          <= res_hi;
          lo          <= res_lo;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= op_div & rt_zero;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq.
module tb_mult_div_seq;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid;
  logic [1:0]      ALUOp;
  logic [5:0]      FuncCode;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            stall;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hilo_out;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int errors = 0;
  int checks = 0;

  mult_div_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUOp(ALUOp),
    .FuncCode(FuncCode), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hilo_out(hilo_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present an instruction at a negedge, let it be accepted, then go idle.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1; ALUOp = 2'b10; FuncCode = f; rs_data = a; rt_data = b;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; ALUOp = 2'b00; FuncCode = 6'd0;
  endtask

  // Count busy cycles until the done cycle (bounded).
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Run one op to completion and check the HI/LO result and flags.
  task automatic run_check(input string name, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz);
    int cnt;
    issue(f, a, b);
    wait_done(cnt);
    checks++;
    if (cnt !== 33) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 33", name, cnt); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b expected 1", name, done); end
    checks++;
    if (div_by_zero !== edz) begin errors++; $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edz); end
    checks++;
    if (hi !== ehi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, ehi); end
    checks++;
    if (lo !== elo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, elo); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL %s pulse_width: got done=%b dbz=%b expected 0 0", name, done, div_by_zero);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; ALUOp = 2'b00; FuncCode = 6'd0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0 0", hi, lo); end
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b stall=%b done=%b dbz=%b expected 0", busy, stall, done, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    issue(F_MULTU, 32'h0000_0007, 32'h0000_0009);
    // counter is 0 now; advance to counter==10
    repeat (10) @(negedge clk);
    ex_valid = 1'b1; ALUOp = 2'b00; FuncCode = F_MFLO;
    #1;
    checks++;
    if (stall !== 1'b0 || hilo_out !== 32'h0) begin
      errors++; $display("FAIL non_rtype_while_busy: got stall=%b hilo_out=%h expected 0 0", stall, hilo_out);
    end
    ex_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midop_reset_busy: got busy=%b done=%b expected 0 0", busy, done); end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midop_reset_discard: got activity=%b expected 0", saw_done); end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midop_reset_hilo: got hi=%h lo=%h expected 0 0", hi, lo); end
  endtask

  task automatic test_mult();
    run_check("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_check("mult_m1m1", F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_check("mult_m3x5", F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
  endtask

  task automatic test_div();
    run_check("div_m7d2",  F_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("divu_7d2",  F_DIVU, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0);
    run_check("div_ovf",   F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_check("div_zero",  F_DIV,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run_check("divu_zero", F_DIVU, 32'hDEAD_0001, 32'h0000_0000, 32'hDEAD_0001, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_stall();
    int scnt;
    issue(F_MULT, 32'h0000_0003, 32'h0000_0004);
    // first busy cycle: an independent add must not stall
    ex_valid = 1'b1; ALUOp = 2'b10; FuncCode = F_ADD;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL add_no_stall: got %b expected 0", stall); end
    @(negedge clk);
    FuncCode = F_MFLO;
    scnt = 0;
    #1;
    while (stall === 1'b1 && scnt < 100) begin
      scnt++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (scnt !== 32) begin errors++; $display("FAIL mflo_stall_cycles: got %0d expected 32", scnt); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL mflo_done_cycle: got done=%b expected 1", done); end
    checks++;
    if (hilo_out !== 32'h0000_000C) begin errors++; $display("FAIL mflo_new_lo: got %h expected 0000000c", hilo_out); end
    @(negedge clk);
    ex_valid = 1'b0; ALUOp = 2'b00; FuncCode = 6'd0;
  endtask

  task automatic test_mthi();
    ex_valid = 1'b1; ALUOp = 2'b10; FuncCode = F_MTHI; rs_data = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", stall); end
    @(negedge clk);
    checks++;
    if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_hi: got %h expected a5a5a5a5", hi); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0 0", busy, done); end
    FuncCode = F_MFHI;
    #1;
    checks++;
    if (hilo_out !== 32'hA5A5_A5A5 || stall !== 1'b0) begin
      errors++; $display("FAIL mfhi_read: got %h stall=%b expected a5a5a5a5 0", hilo_out, stall);
    end
    FuncCode = F_MFLO;
    #1;
    checks++;
    if (hilo_out !== 32'h0000_000C) begin errors++; $display("FAIL mflo_read: got %h expected 0000000c", hilo_out); end
    ALUOp = 2'b01; FuncCode = F_MFHI;
    #1;
    checks++;
    if (hilo_out !== 32'h0) begin errors++; $display("FAIL mfhi_not_rtype: got %h expected 0", hilo_out); end
    @(negedge clk);
    ex_valid = 1'b0; ALUOp = 2'b00; FuncCode = 6'd0;
  endtask

  task automatic test_back_to_back();
    int cnt;
    issue(F_MULTU, 32'h0000_0002, 32'h0000_0003);
    wait_done(cnt);
    checks++;
    if (done !== 1'b1 || lo !== 32'h0000_0006 || hi !== 32'h0) begin
      errors++; $display("FAIL b2b_first: got done=%b hi=%h lo=%h expected 1 0 6", done, hi, lo);
    end
    issue(F_MULTU, 32'h0000_0005, 32'h0000_0007);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: got busy=%b expected 1", busy); end
    wait_done(cnt);
    checks++;
    if (cnt !== 33 || lo !== 32'h0000_0023 || hi !== 32'h0) begin
      errors++; $display("FAIL b2b_second: got cycles=%0d hi=%h lo=%h expected 33 0 23", cnt, hi, lo);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_mult();
    test_div();
    test_stall();
    test_mthi();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
